// File: rtl/mmio_periph_pkg.sv
// rtl/mmio_periph_pkg.sv - shared types, address map and access helpers for mmio_periph
package mmio_periph_pkg;

  // Board I/O widths
  localparam int MFP_N_LED = 16;
  localparam int MFP_N_SW  = 16;
  localparam int MFP_N_PB  = 5;

  // Data-memory access operations (stores use WD/SB/SH, loads use WD/BS/BZ/HS/HZ)
  typedef enum logic [2:0] {
    DM_OP_WD = 3'd0,
    DM_OP_SB = 3'd1,
    DM_OP_SH = 3'd2,
    DM_OP_BS = 3'd3,
    DM_OP_BZ = 3'd4,
    DM_OP_HS = 3'd5,
    DM_OP_HZ = 3'd6
  } dm_op_e;

  // Default region bases
  localparam logic [19:0] GLOB_BASE_DEF  = 20'h80008;
  localparam logic [19:0] STACK_BASE_DEF = 20'h80040;
  localparam logic [23:0] GPIO_BASE_DEF  = 24'hbf8000;

  // Register page offsets
  localparam logic [7:0] REG_LED        = 8'h00;
  localparam logic [7:0] REG_SW         = 8'h04;
  localparam logic [7:0] REG_BTN        = 8'h08;
  localparam logic [7:0] REG_SEG_EN     = 8'h0c;
  localparam logic [7:0] REG_SEG_DIGITS = 8'h10;
  localparam logic [7:0] REG_KEYPAD     = 8'h14;
  localparam logic [7:0] REG_BTN_EVT    = 8'h18;
  localparam logic [7:0] REG_TIMER_CNT  = 8'h1c;
  localparam logic [7:0] REG_TIMER_CMP  = 8'h20;
  localparam logic [7:0] REG_TIMER_CTRL = 8'h24;
  localparam logic [7:0] REG_STATUS     = 8'h28;
  localparam logic [7:0] REG_IRQ_MASK   = 8'h2c;

  // Status bit positions; BTN_IRQ is a read-only mirror of |BTN_EVT
  localparam int ST_TMR_HIT   = 0;
  localparam int ST_ALIGN_ERR = 1;
  localparam int ST_MAP_ERR   = 2;
  localparam int ST_BTN_IRQ   = 3;

  // Timer control bit positions
  localparam int TC_EN     = 0;
  localparam int TC_IRQ_EN = 1;
  localparam int TC_AUTO   = 2;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  // Source of the word captured for the pending load
  typedef enum logic [1:0] {SRC_NONE, SRC_GLOB, SRC_STACK, SRC_REG} rd_src_e;

  function automatic acc_size_e op_size(logic [2:0] op);
    case (op)
      DM_OP_SB, DM_OP_BS, DM_OP_BZ: return SZ_BYTE;
      DM_OP_SH, DM_OP_HS, DM_OP_HZ: return SZ_HALF;
      default:                      return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(logic [2:0] op);
    return (op == DM_OP_BS) || (op == DM_OP_HS);
  endfunction

  function automatic logic is_aligned(acc_size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      default: return lo == 2'b00;
    endcase
  endfunction

  // Little-endian byte enables for a store of size sz at byte lane lo
  function automatic logic [3:0] lane_mask(acc_size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mmio_periph_if.sv
// rtl/mmio_periph_if.sv - MEM-stage data access bus between CPU and mmio_periph
interface mmio_periph_if;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_op;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output dm_w, dm_r, addr, wdata, dm_op,
    input  rdata, rvalid
  );

  modport slave (
    input  dm_w, dm_r, addr, wdata, dm_op,
    output rdata, rvalid
  );
endinterface

// File: rtl/mmio_periph_ram.sv
// rtl/mmio_periph_ram.sv - single RAM region with byte-enable write and registered read
module mmio_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read port samples the array before this cycle's write lands (read-before-write)
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Array write with per-byte enables; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - data-side address decoder with two RAM regions, GPIO/timer page and IRQ
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int          MEM_AW     = 12,
  parameter logic [19:0] GLOB_BASE  = GLOB_BASE_DEF,
  parameter logic [19:0] STACK_BASE = STACK_BASE_DEF,
  parameter logic [23:0] GPIO_BASE  = GPIO_BASE_DEF,
  parameter int          N_LED      = MFP_N_LED,
  parameter int          N_SW       = MFP_N_SW,
  parameter int          N_PB       = MFP_N_PB
) (
  input  logic               clk,
  input  logic               rst,
  mmio_periph_if.slave       bus,
  output logic [N_LED-1:0]   io_led,
  input  logic [N_SW-1:0]    io_switch,
  input  logic [N_PB-1:0]    io_btn,
  input  logic [3:0]         keypad_data,
  output logic [5:0]         seg_en,
  output logic [23:0]        seg_digits,
  output logic               irq
);

  localparam logic [31:0] REGION_BYTES = 32'(1) << (MEM_AW + 2);

  // Decode of the current access
  logic [31:0] glob_off, stack_off;
  logic        in_glob, in_stack, in_gpio, ram_hit, access;
  acc_size_e   acc_sz;
  logic        lane_ok, reg_fmt_ok, reg_off_ok, reg_wr;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [7:0]  reg_off;
  logic        glob_we, glob_re, stack_we, stack_re;
  logic [31:0] glob_rdata, stack_rdata, reg_rd_val;

  // Architectural state
  logic [N_LED-1:0] io_led_q, io_led_d;
  logic [5:0]       seg_en_q, seg_en_d;
  logic [23:0]      seg_digits_q, seg_digits_d;
  logic [31:0]      cnt_q, cnt_d, cmp_q, cmp_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [2:0]       status_q, status_d;
  logic [3:0]       mask_q, mask_d;
  logic [N_PB-1:0]  btn_evt_q, btn_evt_d;
  logic [N_PB-1:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_s3_q, btn_s3_d;

  // Pending-load state
  logic        rvalid_q, rvalid_d;
  rd_src_e     rd_src_q, rd_src_d;
  logic [1:0]  rd_lane_q, rd_lane_d;
  logic [2:0]  rd_op_q, rd_op_d;
  logic [31:0] rd_reg_q, rd_reg_d;

  // Region match, lane alignment, byte enables and store-data replication
  always_comb begin
    glob_off   = bus.addr - {GLOB_BASE, 12'h000};
    stack_off  = bus.addr - {STACK_BASE, 12'h000};
    in_glob    = glob_off < REGION_BYTES;
    in_stack   = stack_off < REGION_BYTES;
    in_gpio    = bus.addr[31:8] == GPIO_BASE;
    ram_hit    = in_glob | in_stack;
    access     = bus.dm_w | bus.dm_r;
    acc_sz     = op_size(bus.dm_op);
    lane_ok    = is_aligned(acc_sz, bus.addr[1:0]);
    be         = lane_mask(acc_sz, bus.addr[1:0]);
    reg_off    = bus.addr[7:0];
    reg_fmt_ok = in_gpio && (bus.dm_op == DM_OP_WD) && (bus.addr[1:0] == 2'b00);
    case (acc_sz)
      SZ_BYTE: st_data = {4{bus.wdata[7:0]}};
      SZ_HALF: st_data = {2{bus.wdata[15:0]}};
      default: st_data = bus.wdata;
    endcase
    glob_we  = bus.dm_w & in_glob & lane_ok;
    glob_re  = bus.dm_r & in_glob & lane_ok;
    stack_we = bus.dm_w & in_stack & lane_ok;
    stack_re = bus.dm_r & in_stack & lane_ok;
  end

  // Register page read mux; also flags offsets that exist on the page
  always_comb begin
    reg_rd_val = '0;
    reg_off_ok = 1'b1;
    case (reg_off)
      REG_LED:        reg_rd_val = 32'(io_led_q);
      REG_SW:         reg_rd_val = 32'(io_switch);
      REG_BTN:        reg_rd_val = 32'(btn_s2_q);
      REG_SEG_EN:     reg_rd_val = 32'(seg_en_q);
      REG_SEG_DIGITS: reg_rd_val = 32'(seg_digits_q);
      REG_KEYPAD:     reg_rd_val = 32'(keypad_data);
      REG_BTN_EVT:    reg_rd_val = 32'(btn_evt_q);
      REG_TIMER_CNT:  reg_rd_val = cnt_q;
      REG_TIMER_CMP:  reg_rd_val = cmp_q;
      REG_TIMER_CTRL: reg_rd_val = 32'(ctrl_q);
      REG_STATUS:     reg_rd_val = {28'h0, |btn_evt_q, status_q};
      REG_IRQ_MASK:   reg_rd_val = 32'(mask_q);
      default:        reg_off_ok = 1'b0;
    endcase
  end

  // Next-state: register writes, timer, button edges, sticky status and load capture
  always_comb begin
    logic [N_PB-1:0] btn_rise, btn_clr;
    logic [2:0]      st_set, st_clr;
    logic            tmr_hit;

    io_led_d     = io_led_q;
    seg_en_d     = seg_en_q;
    seg_digits_d = seg_digits_q;
    cmp_d        = cmp_q;
    ctrl_d       = ctrl_q;
    mask_d       = mask_q;
    reg_wr       = bus.dm_w & reg_fmt_ok & reg_off_ok;

    if (reg_wr) begin
      case (reg_off)
        REG_LED:        io_led_d     = bus.wdata[N_LED-1:0];
        REG_SEG_EN:     seg_en_d     = bus.wdata[5:0];
        REG_SEG_DIGITS: seg_digits_d = bus.wdata[23:0];
        REG_TIMER_CMP:  cmp_d        = bus.wdata;
        REG_TIMER_CTRL: ctrl_d       = bus.wdata[2:0];
        REG_IRQ_MASK:   mask_d       = bus.wdata[3:0];
        default: ;
      endcase
    end

    // Timer: compare match is evaluated on the current count; a CPU write to CNT wins
    cnt_d   = cnt_q;
    tmr_hit = 1'b0;
    if (ctrl_q[TC_EN]) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_q == cmp_q) begin
        tmr_hit = ctrl_q[TC_IRQ_EN];
        if (ctrl_q[TC_AUTO]) cnt_d = '0;
      end
    end
    if (reg_wr && reg_off == REG_TIMER_CNT) cnt_d = bus.wdata;

    // Buttons: two-flop synchroniser plus one history flop for rising-edge detect
    btn_s1_d  = io_btn;
    btn_s2_d  = btn_s1_q;
    btn_s3_d  = btn_s2_q;
    btn_rise  = btn_s2_q & ~btn_s3_q;
    btn_clr   = (reg_wr && reg_off == REG_BTN_EVT) ? bus.wdata[N_PB-1:0] : '0;
    btn_evt_d = (btn_evt_q & ~btn_clr) | btn_rise;

    // Sticky status; a new event in the same cycle as its w1c keeps the bit set
    st_set               = '0;
    st_set[ST_TMR_HIT]   = tmr_hit;
    st_set[ST_ALIGN_ERR] = access & ((ram_hit & ~lane_ok) | (in_gpio & ~reg_fmt_ok));
    st_set[ST_MAP_ERR]   = access & ((~ram_hit & ~in_gpio) | (reg_fmt_ok & ~reg_off_ok));
    st_clr               = (reg_wr && reg_off == REG_STATUS) ? bus.wdata[2:0] : '0;
    status_d             = (status_q & ~st_clr) | st_set;

    // Load capture; failed loads keep SRC_NONE so the returned word is zero
    rvalid_d  = bus.dm_r;
    rd_src_d  = SRC_NONE;
    rd_lane_d = bus.addr[1:0];
    rd_op_d   = bus.dm_op;
    rd_reg_d  = reg_rd_val;
    if (bus.dm_r) begin
      if (in_glob && lane_ok)             rd_src_d = SRC_GLOB;
      else if (in_stack && lane_ok)       rd_src_d = SRC_STACK;
      else if (reg_fmt_ok && reg_off_ok)  rd_src_d = SRC_REG;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_led_q     <= '0;
      seg_en_q     <= 6'h3f;
      seg_digits_q <= '0;
      cnt_q        <= '0;
      cmp_q        <= '0;
      ctrl_q       <= '0;
      status_q     <= '0;
      mask_q       <= '0;
      btn_evt_q    <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      btn_s3_q     <= '0;
      rvalid_q     <= 1'b0;
      rd_src_q     <= SRC_NONE;
      rd_lane_q    <= '0;
      rd_op_q      <= '0;
      rd_reg_q     <= '0;
    end else begin
      io_led_q     <= io_led_d;
      seg_en_q     <= seg_en_d;
      seg_digits_q <= seg_digits_d;
      cnt_q        <= cnt_d;
      cmp_q        <= cmp_d;
      ctrl_q       <= ctrl_d;
      status_q     <= status_d;
      mask_q       <= mask_d;
      btn_evt_q    <= btn_evt_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_s3_q     <= btn_s3_d;
      rvalid_q     <= rvalid_d;
      rd_src_q     <= rd_src_d;
      rd_lane_q    <= rd_lane_d;
      rd_op_q      <= rd_op_d;
      rd_reg_q     <= rd_reg_d;
    end
  end

  mmio_ram #(.AW(MEM_AW)) u_glob_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (glob_we),
    .be    (be),
    .addr  (glob_off[MEM_AW+1:2]),
    .wdata (st_data),
    .re    (glob_re),
    .rdata (glob_rdata)
  );

  mmio_ram #(.AW(MEM_AW)) u_stack_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (stack_we),
    .be    (be),
    .addr  (stack_off[MEM_AW+1:2]),
    .wdata (st_data),
    .re    (stack_re),
    .rdata (stack_rdata)
  );

  // Load data: pick the captured word, extract the lane, then zero/sign extend
  always_comb begin
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sgn;
    case (rd_src_q)
      SRC_GLOB:  rd_word = glob_rdata;
      SRC_STACK: rd_word = stack_rdata;
      SRC_REG:   rd_word = rd_reg_q;
      default:   rd_word = '0;
    endcase
    rd_byte = rd_word[{rd_lane_q, 3'b000} +: 8];
    rd_half = rd_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    sgn     = op_signed(rd_op_q);
    case (op_size(rd_op_q))
      SZ_BYTE: bus.rdata = {{24{sgn & rd_byte[7]}}, rd_byte};
      SZ_HALF: bus.rdata = {{16{sgn & rd_half[15]}}, rd_half};
      default: bus.rdata = rd_word;
    endcase
  end

  assign bus.rvalid = rvalid_q;
  assign io_led     = io_led_q;
  assign seg_en     = seg_en_q;
  assign seg_digits = seg_digits_q;
  assign irq        = |({|btn_evt_q, status_q} & mask_q);

endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - self-checking bench for mmio_periph
module tb_mmio_periph;
  import mmio_periph_pkg::*;

  localparam logic [31:0] GLOB  = 32'h80008000;
  localparam logic [31:0] STACK = 32'h80040000;
  localparam logic [31:0] GPIO  = 32'hbf800000;
  localparam logic [31:0] SPAN  = 32'h00004000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] io_led;
  logic [15:0] io_switch = '0;
  logic [4:0]  io_btn = '0;
  logic [3:0]  keypad_data = '0;
  logic [5:0]  seg_en;
  logic [23:0] seg_digits;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mm [logic [31:0]];
  logic [2:0]  st_m;

  mmio_periph_if bus ();

  mmio_periph dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .io_led      (io_led),
    .io_switch   (io_switch),
    .io_btn      (io_btn),
    .keypad_data (keypad_data),
    .seg_en      (seg_en),
    .seg_digits  (seg_digits),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive at a negedge, return what is visible at the next negedge
  task automatic acc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] op, output logic [31:0] rd, output logic rv);
    bus.dm_w = w; bus.dm_r = r; bus.addr = a; bus.wdata = d; bus.dm_op = op;
    @(negedge clk);
    rd = bus.rdata; rv = bus.rvalid;
    bus.dm_w = 1'b0; bus.dm_r = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x; logic v;
    acc(1'b1, 1'b0, a, d, DM_OP_WD, x, v);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] val);
    logic v;
    acc(1'b0, 1'b1, a, 32'h0, DM_OP_WD, val, v);
  endtask

  function automatic int nbytes(logic [2:0] op);
    if (op == DM_OP_WD) return 4;
    if (op == DM_OP_SB || op == DM_OP_BS || op == DM_OP_BZ) return 1;
    return 2;
  endfunction

  function automatic logic in_ram(logic [31:0] a);
    return ((a - GLOB) < SPAN) || ((a - STACK) < SPAN);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b exp 0", bus.rvalid); end
    tests++; if (seg_en !== 6'h3f) begin fails++; $display("FAIL rst_seg_en: got %h exp 3f", seg_en); end
    wr(GPIO + 32'h00, 32'h3c);
    wr(GPIO + 32'h0c, 32'h00);
    wr(GPIO + 32'h10, 32'h123456);
    bus.dm_r = 1'b1; bus.addr = GPIO; bus.dm_op = DM_OP_WD;
    @(posedge clk); #2;
    tests++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h3c) begin fails++; $display("FAIL pre_rst_read: got %b/%h exp 1/3c", bus.rvalid, bus.rdata); end
    rst = 1'b0; #1;
    tests++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin fails++; $display("FAIL rst_mid_read: got %b/%h exp 0/0", bus.rvalid, bus.rdata); end
    tests++; if (io_led !== 16'h0 || seg_en !== 6'h3f || seg_digits !== 24'h0 || irq !== 1'b0) begin
      fails++; $display("FAIL rst_outputs: got led=%h en=%h dig=%h irq=%b", io_led, seg_en, seg_digits, irq); end
    @(negedge clk); bus.dm_r = 1'b0; rst = 1'b1;
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_status: got %h exp 0", v); end
    rd(GPIO + 32'h1c, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_cnt: got %h exp 0", v); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] v; logic rv;
    wr(GLOB, 32'h0);
    acc(1'b1, 1'b0, GLOB + 1, 32'h000000aa, DM_OP_SB, v, rv);
    tests++; if (rv !== 1'b0) begin fails++; $display("FAIL store_rvalid: got %b exp 0", rv); end
    acc(1'b1, 1'b0, GLOB + 3, 32'h000000bb, DM_OP_SB, v, rv);
    acc(1'b0, 1'b1, GLOB, 32'h0, DM_OP_WD, v, rv);
    tests++; if (v !== 32'hbb00aa00 || rv !== 1'b1) begin fails++; $display("FAIL lw_lanes: got %h/%b exp bb00aa00/1", v, rv); end
    acc(1'b0, 1'b1, GLOB + 3, 32'h0, DM_OP_BS, v, rv);
    tests++; if (v !== 32'hffffffbb) begin fails++; $display("FAIL lb_sign: got %h exp ffffffbb", v); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] v; logic rv;
    wr(STACK + 4, 32'hcafef00d);
    acc(1'b1, 1'b1, STACK + 4, 32'h12345678, DM_OP_WD, v, rv);
    tests++; if (v !== 32'hcafef00d) begin fails++; $display("FAIL rbw_old: got %h exp cafef00d", v); end
    rd(STACK + 4, v);
    tests++; if (v !== 32'h12345678) begin fails++; $display("FAIL rbw_new: got %h exp 12345678", v); end
    acc(1'b0, 1'b1, STACK + 6, 32'h0, DM_OP_HZ, v, rv);
    tests++; if (v !== 32'h00001234) begin fails++; $display("FAIL lhu: got %h exp 00001234", v); end
  endtask

  task automatic test_align();
    logic [31:0] v; logic rv;
    acc(1'b1, 1'b0, GLOB + 1, 32'hffff, DM_OP_SH, v, rv);
    rd(GLOB, v);
    tests++; if (v !== 32'hbb00aa00) begin fails++; $display("FAIL misaligned_sh_mem: got %h exp bb00aa00", v); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL align_status: got %h exp 2", v); end
    wr(GPIO + 32'h28, 32'h2);
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL align_clear: got %h exp 0", v); end
  endtask

  task automatic test_gpio();
    logic [31:0] v, sw; logic rv;
    wr(GPIO, 32'h5);
    rd(GPIO, v);
    tests++; if (v !== 32'h5 || io_led !== 16'h5) begin fails++; $display("FAIL led: got %h/%h exp 5/5", v, io_led); end
    sw = $urandom; io_switch = sw[15:0]; keypad_data = sw[19:16];
    rd(GPIO + 32'h04, v);
    tests++; if (v !== {16'h0, sw[15:0]}) begin fails++; $display("FAIL sw: got %h exp %h", v, {16'h0, sw[15:0]}); end
    rd(GPIO + 32'h14, v);
    tests++; if (v !== {28'h0, sw[19:16]}) begin fails++; $display("FAIL keypad: got %h exp %h", v, {28'h0, sw[19:16]}); end
    wr(GPIO + 32'h10, 32'habcdef12);
    wr(GPIO + 32'h0c, 32'h2a);
    tests++; if (seg_digits !== 24'hcdef12 || seg_en !== 6'h2a) begin fails++; $display("FAIL seg: got %h/%h exp cdef12/2a", seg_digits, seg_en); end
    acc(1'b0, 1'b1, GPIO + 32'h30, 32'h0, DM_OP_WD, v, rv);
    tests++; if (v !== 32'h0 || rv !== 1'b1) begin fails++; $display("FAIL unlisted_read: got %h/%b exp 0/1", v, rv); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h4) begin fails++; $display("FAIL map_status: got %h exp 4", v); end
    wr(GPIO + 32'h28, 32'h7);
    acc(1'b0, 1'b1, GPIO, 32'h0, DM_OP_BZ, v, rv);
    tests++; if (v !== 32'h0 || rv !== 1'b1) begin fails++; $display("FAIL reg_byte_read: got %h/%b exp 0/1", v, rv); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL reg_byte_status: got %h exp 2", v); end
    wr(GPIO + 32'h28, 32'h7);
  endtask

  task automatic test_random();
    logic [31:0] a, d, v, exp; logic rv; logic [2:0] op;
    logic [2:0] st_ops [3];
    logic [2:0] ld_ops [5];
    int n;
    st_ops = '{DM_OP_WD, DM_OP_SB, DM_OP_SH};
    ld_ops = '{DM_OP_WD, DM_OP_BS, DM_OP_BZ, DM_OP_HS, DM_OP_HZ};
    st_m = '0;
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 2; r++) begin
        a = (r == 0 ? GLOB + 32'h40 : STACK + 32'h100) + 32'(4 * w);
        d = $urandom;
        wr(a, d);
        for (int b = 0; b < 4; b++) mm[a + 32'(b)] = d[8*b +: 8];
      end
    end
    for (int it = 0; it < 300; it++) begin
      a = ($urandom_range(0, 1) == 0 ? GLOB + 32'h40 : STACK + 32'h100) + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = 32'h80010000 + 32'($urandom_range(0, 63));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        op = st_ops[$urandom_range(0, 2)];
        n = nbytes(op);
        if (!in_ram(a)) st_m[2] = 1'b1;
        else if (a % n != 0) st_m[1] = 1'b1;
        else for (int b = 0; b < n; b++) mm[a + 32'(b)] = d[8*b +: 8];
        acc(1'b1, 1'b0, a, d, op, v, rv);
        tests++; if (rv !== 1'b0) begin fails++; $display("FAIL rnd_store_rvalid: got %b exp 0 addr %h", rv, a); end
      end else begin
        op = ld_ops[$urandom_range(0, 4)];
        n = nbytes(op);
        exp = '0;
        if (!in_ram(a)) st_m[2] = 1'b1;
        else if (a % n != 0) st_m[1] = 1'b1;
        else begin
          for (int b = 0; b < n; b++) exp[8*b +: 8] = mm[a + 32'(b)];
          if (op == DM_OP_BS && exp[7])  exp = exp | 32'hffffff00;
          if (op == DM_OP_HS && exp[15]) exp = exp | 32'hffff0000;
        end
        acc(1'b0, 1'b1, a, 32'h0, op, v, rv);
        tests++; if (v !== exp || rv !== 1'b1) begin fails++; $display("FAIL rnd_load: addr %h op %0d got %h/%b exp %h/1", a, op, v, rv, exp); end
      end
      if (it % 25 == 24) begin
        rd(GPIO + 32'h28, v);
        tests++; if (v !== {29'h0, st_m}) begin fails++; $display("FAIL rnd_status: got %h exp %h", v, {29'h0, st_m}); end
        wr(GPIO + 32'h28, 32'h7);
        st_m = '0;
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] v; int cyc;
    wr(GPIO + 32'h1c, 32'h0);
    wr(GPIO + 32'h20, 32'd5);
    wr(GPIO + 32'h2c, 32'h1);
    wr(GPIO + 32'h24, 32'h7);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (irq === 1'b1) begin cyc = i; break; end
    end
    tests++; if (cyc != 6) begin fails++; $display("FAIL tmr_irq_cycle: got %0d exp 6", cyc); end
    rd(GPIO + 32'h1c, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL tmr_auto_cnt: got %h exp 0", v); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL tmr_status: got %h exp 1", v); end
    wr(GPIO + 32'h28, 32'h1);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL tmr_irq_clear: got %b exp 0", irq); end
    wr(GPIO + 32'h24, 32'h0);
    wr(GPIO + 32'h1c, 32'h0);
    wr(GPIO + 32'h20, 32'd2);
    wr(GPIO + 32'h24, 32'h1);
    repeat (10) @(negedge clk);
    rd(GPIO + 32'h1c, v);
    tests++; if (v !== 32'd10) begin fails++; $display("FAIL tmr_free_run: got %h exp a", v); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL tmr_no_irq_en: got %h exp 0", v); end
    wr(GPIO + 32'h24, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v; logic rv;
    logic [31:0] exp [3];
    exp = '{32'hfffffffe, 32'hffffffff, 32'h0};
    wr(GPIO + 32'h1c, 32'hfffffffe);
    wr(GPIO + 32'h24, 32'h1);
    for (int i = 0; i < 3; i++) begin
      acc(1'b0, 1'b1, GPIO + 32'h1c, 32'h0, DM_OP_WD, v, rv);
      tests++; if (v !== exp[i] || rv !== 1'b1) begin fails++; $display("FAIL b2b_wrap[%0d]: got %h/%b exp %h/1", i, v, rv, exp[i]); end
    end
    wr(GPIO + 32'h24, 32'h0);
    wr(GPIO + 32'h28, 32'h7);
  endtask

  task automatic test_btn();
    logic [31:0] v; logic rv; int ones;
    io_btn[0] = 1'b1;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      acc(1'b1, 1'b1, GPIO + 32'h18, 32'h1, DM_OP_WD, v, rv);
      if (v[0] === 1'b1) ones++;
    end
    tests++; if (ones != 1) begin fails++; $display("FAIL btn_set_wins: got %0d exp 1", ones); end
    rd(GPIO + 32'h18, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL btn_cleared: got %h exp 0", v); end
    io_btn[1] = 1'b1;
    repeat (5) @(negedge clk);
    rd(GPIO + 32'h18, v);
    tests++; if (v !== 32'h2) begin fails++; $display("FAIL btn_evt: got %h exp 2", v); end
    rd(GPIO + 32'h08, v);
    tests++; if (v !== 32'h3) begin fails++; $display("FAIL btn_level: got %h exp 3", v); end
    rd(GPIO + 32'h28, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL btn_status: got %h exp 8", v); end
    wr(GPIO + 32'h2c, 32'h8);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL btn_irq: got %b exp 1", irq); end
    wr(GPIO + 32'h18, 32'h2);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL btn_irq_clear: got %b exp 0", irq); end
    wr(GPIO + 32'h2c, 32'h0);
    wr(GPIO, 32'h5);
    rd(GPIO, v);
    tests++; if (v !== 32'h5) begin fails++; $display("FAIL led_final: got %h exp 5", v); end
  endtask

  initial begin
    bus.dm_w = 1'b0; bus.dm_r = 1'b0; bus.addr = '0; bus.wdata = '0; bus.dm_op = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_byte_lanes();
    test_read_before_write();
    test_align();
    test_gpio();
    test_random();
    test_timer();
    test_back_to_back();
    test_btn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
